srl_fifo_ctrl: RTL and testbench

Parametrised shift-register (SRL) FIFO with a full ap_fifo handshake. It generalises the single-bit start-token shift register into a data FIFO of any width and depth, adding occupancy tracking, programmable almost-full/almost-empty flags and an optional registered first-word-fall-through output stage. It sits between dataflow processes, such as PE start/data channels, inside the generated Linear_Layer kernels.

---
 rtl/srl_fifo_pkg.sv | 15 +
 rtl/srl_fifo_storage.sv | 25 ++
 rtl/srl_fifo_ctrl.sv | 97 +++++++++
 tb/tb_srl_fifo_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/srl_fifo_pkg.sv
// srl_fifo_pkg: shared output-mode constants and sizing helpers for the SRL FIFO
package srl_fifo_pkg;
    localparam int OUT_MODE_COMB = 0;
    localparam int OUT_MODE_REG  = 1;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int afull_default(input int depth);
        return depth - 2;
    endfunction
endpackage

// File: rtl/srl_fifo_storage.sv
// srl_fifo_storage: reset-free shift register with addressed read, maps onto SRL primitives
module srl_fifo_storage
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
        end
    end

    assign dout = mem_q[addr];
endmodule

// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: ap_fifo handshake SRL FIFO with occupancy, almost flags and optional output register
module srl_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int OUT_REG    = OUT_MODE_COMB,
    parameter int AFULL_TH   = afull_default(DEPTH),
    parameter int AEMPTY_TH  = 2,
    parameter int CNT_W      = clog2(DEPTH + 2)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [CNT_W-1:0]      count,
    output logic                  almost_full,
    output logic                  almost_empty
);
    localparam int              AW       = clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);
    localparam bit              REG_OUT  = (OUT_REG == OUT_MODE_REG);

    logic [CNT_W-1:0]      sc_q, sc_d, count_q, count_d;
    logic                  ov_q, ov_d, full_n_q, full_n_d, empty_n_q, empty_n_d;
    logic                  afull_q, afull_d, aempty_q, aempty_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, srl_dout;
    logic                  wr, rd, ld, pop;
    logic [AW-1:0]         addr;

    always_comb begin
        wr        = if_write & if_write_ce & full_n_q;
        rd        = if_read & if_read_ce & empty_n_q;
        ld        = REG_OUT & (~ov_q | rd) & (sc_q != '0);
        pop       = REG_OUT ? ld : rd;
        addr      = (sc_q == '0) ? '0 : AW'(sc_q - CNT_W'(1));
        sc_d      = sc_q + CNT_W'(wr) - CNT_W'(pop);
        ov_d      = REG_OUT & (ld | (ov_q & ~rd));
        count_d   = sc_d + CNT_W'(ov_d);
        dout_d    = ld ? srl_dout : dout_q;
        full_n_d  = sc_d < DEPTH_C;
        empty_n_d = REG_OUT ? ov_d : (count_d != '0);
        afull_d   = count_d >= AFULL_C;
        aempty_d  = count_d <= AEMPTY_C;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sc_q      <= '0;
            count_q   <= '0;
            ov_q      <= 1'b0;
            dout_q    <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
        end else begin
            sc_q      <= sc_d;
            count_q   <= count_d;
            ov_q      <= ov_d;
            dout_q    <= dout_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

    srl_fifo_storage #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_srl (
        .clk (ap_clk),
        .we  (wr),
        .addr(addr),
        .din (if_din),
        .dout(srl_dout)
    );

    assign if_full_n    = full_n_q;
    assign if_empty_n   = empty_n_q;
    assign count        = count_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign if_dout      = REG_OUT ? dout_q : srl_dout;

    a_sc_bound: assert property (@(posedge ap_clk) disable iff (!ap_rst_n) sc_q <= DEPTH_C);
endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// tb_srl_fifo_ctrl: queue-model bench for a combinational-output and a registered-output FIFO instance
module tb_srl_fifo_ctrl;
    logic       clk = 0, rst_n = 0;
    logic [1:0] w = 0, r = 0, wce = 2'b11, rce = 2'b11;
    logic [7:0] din [2];
    logic [1:0] full_n, empty_n, af, ae;
    logic [7:0] dout [2];
    logic [2:0] cnt [2];
    int         tests = 0, fails = 0;

    logic [7:0] mq [2][8];
    int         mn [2] = '{0, 0};
    bit         mov [2] = '{0, 0};
    logic [7:0] mod [2] = '{8'h0, 8'h0};
    logic [7:0] seq [102];

    always #5 clk = ~clk;

    srl_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(4), .OUT_REG(0), .AFULL_TH(3), .AEMPTY_TH(1)) u0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .if_write_ce(wce[0]), .if_write(w[0]), .if_din(din[0]),
        .if_full_n(full_n[0]), .if_read_ce(rce[0]), .if_read(r[0]), .if_dout(dout[0]),
        .if_empty_n(empty_n[0]), .count(cnt[0]), .almost_full(af[0]), .almost_empty(ae[0]));

    srl_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(4), .OUT_REG(1), .AFULL_TH(3), .AEMPTY_TH(1)) u1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .if_write_ce(wce[1]), .if_write(w[1]), .if_din(din[1]),
        .if_full_n(full_n[1]), .if_read_ce(rce[1]), .if_read(r[1]), .if_dout(dout[1]),
        .if_empty_n(empty_n[1]), .count(cnt[1]), .almost_full(af[1]), .almost_empty(ae[1]));

    function automatic int ecount(input int m);
        return mn[m] + int'(mov[m]);
    endfunction

    function automatic bit eempty_n(input int m);
        return (m == 1) ? mov[m] : (mn[m] > 0);
    endfunction

    function automatic logic [7:0] edout(input int m);
        return (m == 1) ? mod[m] : mq[m][0];
    endfunction

    task automatic mpop(input int m);
        for (int i = 0; i < 7; i++) mq[m][i] = mq[m][i+1];
        mn[m] = mn[m] - 1;
    endtask

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[u%0d] at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    // Reference: u0 pops straight from the queue; u1 has a one-word holding stage fed from the queue head
    always @(posedge clk or negedge rst_n) begin
        bit wa, ra, ld;
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                mn[m] = 0; mov[m] = 0; mod[m] = 8'h0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                wa = w[m] && wce[m] && (mn[m] < 4);
                ra = r[m] && rce[m] && eempty_n(m);
                ld = (m == 1) && (!mov[m] || ra) && (mn[m] > 0);
                if (m == 0 && ra) mpop(m);
                if (ld) begin
                    mod[m] = mq[m][0];
                    mpop(m);
                end
                if (m == 1) mov[m] = ld || (mov[m] && !ra);
                if (wa) begin
                    mq[m][mn[m]] = din[m];
                    mn[m] = mn[m] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
                chk("m_count", m, 32'(cnt[m]), ecount(m));
                chk("m_full_n", m, 32'(full_n[m]), 32'(mn[m] < 4));
                chk("m_empty_n", m, 32'(empty_n[m]), 32'(eempty_n(m)));
                chk("m_afull", m, 32'(af[m]), 32'(ecount(m) >= 3));
                chk("m_aempty", m, 32'(ae[m]), 32'(ecount(m) <= 1));
                if (m == 1 || eempty_n(m)) chk("m_dout", m, 32'(dout[m]), 32'(edout(m)));
            end
        end
    end

    task automatic step(input logic [1:0] wv, input logic [1:0] rv, input logic [7:0] d0, input logic [7:0] d1);
        w = wv; r = rv; din[0] = d0; din[1] = d1;
        @(negedge clk);
        w = 0; r = 0;
    endtask

    task automatic drain();
        repeat (8) step(2'b00, 2'b11, 8'h0, 8'h0);
    endtask

    initial begin
        logic [1:0] wv, rv;
        logic [7:0] d;
        int         pw;
        din[0] = 0; din[1] = 0;
        repeat (2) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("rst_count", m, 32'(cnt[m]), 0);
            chk("rst_full_n", m, 32'(full_n[m]), 1);
            chk("rst_empty_n", m, 32'(empty_n[m]), 0);
            chk("rst_afull", m, 32'(af[m]), 0);
            chk("rst_aempty", m, 32'(ae[m]), 1);
        end
        chk("rst_dout", 1, 32'(dout[1]), 0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) step(2'b01, 2'b00, 8'hA1 + 8'(i), 8'h0);
        chk("t1_full_n", 0, 32'(full_n[0]), 0);
        chk("t1_count", 0, 32'(cnt[0]), 4);
        chk("t1_head", 0, 32'(dout[0]), 32'hA1);
        step(2'b01, 2'b01, 8'hFF, 8'h0);
        chk("t2_count", 0, 32'(cnt[0]), 3);
        chk("t2_full_n", 0, 32'(full_n[0]), 1);
        for (int i = 0; i < 3; i++) begin
            chk("t2_pop", 0, 32'(dout[0]), 32'hA2 + i);
            step(2'b00, 2'b01, 8'h0, 8'h0);
        end
        chk("t2_empty_n", 0, 32'(empty_n[0]), 0);
        for (int i = 0; i < 4; i++) step(2'b01, 2'b00, 8'hA1 + 8'(i), 8'h0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_pop", 0, 32'(dout[0]), 32'hA1 + i);
            step(2'b00, 2'b01, 8'h0, 8'h0);
        end
        chk("t1_empty_n", 0, 32'(empty_n[0]), 0);
        chk("t1_count0", 0, 32'(cnt[0]), 0);

        step(2'b10, 2'b00, 8'h0, 8'h5C);
        chk("t3_lat1_empty_n", 1, 32'(empty_n[1]), 0);
        chk("t3_lat1_count", 1, 32'(cnt[1]), 1);
        step(2'b00, 2'b00, 8'h0, 8'h0);
        chk("t3_lat2_empty_n", 1, 32'(empty_n[1]), 1);
        chk("t3_lat2_dout", 1, 32'(dout[1]), 32'h5C);
        chk("t3_lat2_count", 1, 32'(cnt[1]), 1);
        for (int i = 1; i < 4; i++) step(2'b10, 2'b00, 8'h0, 8'h5C + 8'(i));
        chk("t3_cnt4_full_n", 1, 32'(full_n[1]), 1);
        step(2'b10, 2'b00, 8'h0, 8'h60);
        chk("t3_cap_count", 1, 32'(cnt[1]), 5);
        chk("t3_cap_full_n", 1, 32'(full_n[1]), 0);
        step(2'b10, 2'b00, 8'h0, 8'hEE);
        chk("t3_drop_count", 1, 32'(cnt[1]), 5);
        for (int i = 0; i < 5; i++) begin
            chk("t3_pop", 1, 32'(dout[1]), 32'h5C + i);
            step(2'b00, 2'b10, 8'h0, 8'h0);
        end
        chk("t3_empty_n", 1, 32'(empty_n[1]), 0);

        seq[0] = 8'h31; seq[1] = 8'h32;
        step(2'b11, 2'b00, seq[0], seq[0]);
        step(2'b11, 2'b00, seq[1], seq[1]);
        for (int i = 0; i < 100; i++) begin
            d = 8'($urandom);
            seq[i+2] = d;
            chk("t4_dout", 0, 32'(dout[0]), 32'(seq[i]));
            chk("t4_dout", 1, 32'(dout[1]), 32'(seq[i]));
            step(2'b11, 2'b11, d, d);
            chk("t4_count", 0, 32'(cnt[0]), 2);
            chk("t4_count", 1, 32'(cnt[1]), 2);
        end
        drain();

        for (int k = 1; k <= 4; k++) begin
            step(2'b11, 2'b00, 8'(k), 8'(k));
            for (int m = 0; m < 2; m++) begin
                chk("t5_fill_afull", m, 32'(af[m]), 32'(k >= 3));
                chk("t5_fill_aempty", m, 32'(ae[m]), 32'(k <= 1));
            end
        end
        for (int k = 3; k >= 0; k--) begin
            step(2'b00, 2'b11, 8'h0, 8'h0);
            for (int m = 0; m < 2; m++) begin
                chk("t5_drain_count", m, 32'(cnt[m]), k);
                chk("t5_drain_afull", m, 32'(af[m]), 32'(k >= 3));
                chk("t5_drain_aempty", m, 32'(ae[m]), 32'(k <= 1));
            end
        end

        for (int c = 0; c < 600; c++) begin
            pw = ((c / 100) % 2 == 1) ? 30 : 75;
            for (int m = 0; m < 2; m++) begin
                wv[m]  = $urandom_range(0, 99) < pw;
                rv[m]  = $urandom_range(0, 99) < (100 - pw);
                wce[m] = $urandom_range(0, 9) != 0;
                rce[m] = $urandom_range(0, 9) != 0;
            end
            step(wv, rv, 8'($urandom), 8'($urandom));
        end
        wce = 2'b11; rce = 2'b11;
        drain();

        for (int i = 1; i <= 3; i++) step(2'b11, 2'b00, 8'(i), 8'(i));
        chk("t6_pre_count", 0, 32'(cnt[0]), 3);
        chk("t6_pre_count", 1, 32'(cnt[1]), 3);
        #2 rst_n = 0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("t6_async_count", m, 32'(cnt[m]), 0);
            chk("t6_async_empty_n", m, 32'(empty_n[m]), 0);
            chk("t6_async_full_n", m, 32'(full_n[m]), 1);
            chk("t6_async_aempty", m, 32'(ae[m]), 1);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        step(2'b11, 2'b00, 8'h11, 8'h11);
        chk("t6_after_empty_n", 0, 32'(empty_n[0]), 1);
        chk("t6_after_dout", 0, 32'(dout[0]), 32'h11);
        chk("t6_after_lat", 1, 32'(empty_n[1]), 0);
        step(2'b00, 2'b00, 8'h0, 8'h0);
        chk("t6_after_empty_n", 1, 32'(empty_n[1]), 1);
        chk("t6_after_dout", 1, 32'(dout[1]), 32'h11);
        step(2'b00, 2'b11, 8'h0, 8'h0);
        chk("t6_final_empty_n", 0, 32'(empty_n[0]), 0);
        chk("t6_final_empty_n", 1, 32'(empty_n[1]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
